// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// One byte per grant; each grant waits for the transmitter busy flag to rise and fall, or times out.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BUSY_WAIT = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_wrsig,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      tx_timeout
);
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    rr_ptr, rr_nx, win, grant_nx;
  logic [IDX_W-1:0]   idx;
  logic               found;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [NUM_REQ-1:0] ready_nx;
  logic [DATA_W-1:0]  data_nx;
  logic               wrsig_nx, timeout_nx;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ready_nx   = '0;
    wrsig_nx   = 1'b0;
    timeout_nx = 1'b0;
    data_nx    = tx_data;
    grant_nx   = grant_id;
    rr_nx      = rr_ptr;
    cnt_nx     = cnt;
    unique case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          data_nx  = req_data[win*DATA_W +: DATA_W];
          grant_nx = win;
          rr_nx    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          ready_nx = NUM_REQ'(1) << win;
          wrsig_nx = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: begin
        cnt_nx   = '0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if ((int'(cnt) + 1) >= (BUSY_WAIT - 1)) begin
          // The byte is dropped, not retried: the requester already saw its accept.
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      tx_data    <= '0;
      tx_wrsig   <= 1'b0;
      grant_id   <= '0;
      active     <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_nx;
      cnt        <= cnt_nx;
      req_ready  <= ready_nx;
      tx_data    <= data_nx;
      tx_wrsig   <= wrsig_nx;
      grant_id   <= grant_nx;
      active     <= (state_nx != IDLE);
      tx_timeout <= timeout_nx;
    end
  end

endmodule
